// File: rtl/mem_arbiter_pkg.sv
// Shared widths, latency default and type definitions for the datamem arbiter.
package mem_arbiter_pkg;

   localparam int WORD_SIZE        = 32;
   localparam int BLOCK_SIZE       = 1024;
   localparam int CACHE_OFFSET_LEN = 7;
   localparam int MEM_LAT_DEF      = 4;
   localparam int LOCK_IDLE_MAX    = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      SIDE_I = 1'b0,
      SIDE_D = 1'b1
   } side_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache request/response and datamem signals around the arbiter.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = WORD_SIZE,
   parameter int BLOCK_W = BLOCK_SIZE
);

   logic               i_req;
   logic [ADDR_W-1:0]  i_addr;
   logic               i_ack;
   logic [BLOCK_W-1:0] i_rdata;

   logic               d_req;
   logic               d_we;
   logic               d_lock;
   logic [ADDR_W-1:0]  d_addr;
   logic [BLOCK_W-1:0] d_wdata;
   logic               d_ack;
   logic [BLOCK_W-1:0] d_rdata;

   logic               flush_req;

   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_re;
   logic               mem_we;
   logic [BLOCK_W-1:0] mem_wdata;
   logic [BLOCK_W-1:0] mem_rdata;
   logic               mem_flush;

   modport master (
      output i_req, i_addr, d_req, d_we, d_lock, d_addr, d_wdata, flush_req, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_re, mem_we, mem_wdata, mem_flush
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_lock, d_addr, d_wdata, flush_req, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_re, mem_we, mem_wdata, mem_flush
   );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick between icache and dcache; a held
// lock reserves the next grant for the dcache even when it is not requesting.
module rr_pick2
   import mem_arbiter_pkg::*;
(
   input  logic  i_req,
   input  logic  d_req,
   input  side_t last_grant,
   input  logic  lock,
   output logic  valid,
   output side_t pick
);

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves one unassigned and infers a latch.
      valid = 1'b0;
      pick  = SIDE_I;
      if (lock) begin
         valid = d_req;
         pick  = SIDE_D;
      end else if (i_req && d_req) begin
         valid = 1'b1;
         pick  = (last_grant == SIDE_I) ? SIDE_D : SIDE_I;
      end else if (d_req) begin
         valid = 1'b1;
         pick  = SIDE_D;
      end else if (i_req) begin
         valid = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the block-wide datamem port between icache refills and dcache
// refills/write-backs/flush, with a fixed memory latency per transaction.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = WORD_SIZE,
   parameter int BLOCK_W = BLOCK_SIZE,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   localparam int                CNT_W       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0]  CNT_INIT    = CNT_W'(MEM_LAT - 1);
   localparam int                LOCK_W      = $clog2(LOCK_IDLE_MAX);
   localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCK_IDLE_MAX - 1);
   localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << CACHE_OFFSET_LEN) - 1);

   state_t             state, state_nx;
   side_t              gnt_side, last_grant, pick;
   logic               gnt_we, lock, flushing;
   logic               pick_valid, flush_go, start;
   logic [CNT_W-1:0]   cnt;
   logic [LOCK_W-1:0]  lock_cnt;
   logic [ADDR_W-1:0]  addr_sel, mem_addr_q;
   logic [BLOCK_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;

   // A pending flush shuts icache out so the dcache can drain first.
   rr_pick2 u_pick (
      .i_req      (bus.i_req & ~bus.flush_req),
      .d_req      (bus.d_req),
      .last_grant (last_grant),
      .lock       (lock),
      .valid      (pick_valid),
      .pick       (pick)
   );

   assign flush_go = bus.flush_req & ~bus.d_req;
   assign start    = (state == ST_IDLE) & ~flushing & ~flush_go & pick_valid;
   assign addr_sel = (pick == SIDE_D) ? bus.d_addr : bus.i_addr;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start) state_nx = ST_BUSY;
         ST_BUSY: if (cnt == '0) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_side    <= SIDE_I;
         last_grant  <= SIDE_I;
         gnt_we      <= 1'b0;
         lock        <= 1'b0;
         lock_cnt    <= '0;
         flushing    <= 1'b0;
         cnt         <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (flushing) begin
                  if (!bus.flush_req) flushing <= 1'b0;
               end else if (flush_go) begin
                  flushing <= 1'b1;
               end else if (pick_valid) begin
                  gnt_side   <= pick;
                  gnt_we     <= (pick == SIDE_D) & bus.d_we;
                  mem_addr_q <= addr_sel & ~OFFSET_MASK;
                  cnt        <= CNT_INIT;
                  if (pick == SIDE_D) mem_wdata_q <= bus.d_wdata;
               end
               // Safety release if a locked dcache never comes back.
               if (lock && !bus.d_req) begin
                  if (lock_cnt == LOCK_LAST) begin
                     lock     <= 1'b0;
                     lock_cnt <= '0;
                  end else begin
                     lock_cnt <= lock_cnt + 1'b1;
                  end
               end else begin
                  lock_cnt <= '0;
               end
            end
            ST_BUSY: begin
               if (cnt == '0) begin
                  if (!gnt_we) begin
                     if (gnt_side == SIDE_D) d_rdata_q <= bus.mem_rdata;
                     else                    i_rdata_q <= bus.mem_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               last_grant <= gnt_side;
               lock       <= (gnt_side == SIDE_D) & bus.d_lock;
               lock_cnt   <= '0;
            end
            default: ;
         endcase
      end
   end

   // Strobes and acks decode straight from state so reset drops them at once.
   assign bus.mem_re    = (state == ST_BUSY) & ~gnt_we;
   assign bus.mem_we    = (state == ST_BUSY) &  gnt_we;
   assign bus.i_ack     = (state == ST_DONE) & (gnt_side == SIDE_I);
   assign bus.d_ack     = (state == ST_DONE) & (gnt_side == SIDE_D);
   assign bus.mem_flush = flushing;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, lone/contended reads, locked
// write-back+refill, lock safety release, flush ordering and mid-busy reset.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW  = 32;
   localparam int BW  = 1024;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   i_ack_cnt = 0;
   int   d_ack_cnt = 0;

   mem_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] pattern(input logic [AW-1:0] a);
      logic [BW-1:0] b;
      for (int k = 0; k < BW/32; k++) b[k*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(k + 1));
      return b;
   endfunction

   function automatic logic [31:0] fold(input logic [BW-1:0] b);
      logic [31:0] f;
      f = '0;
      for (int k = 0; k < BW/32; k++) f = {f[30:0], f[31]} ^ b[k*32 +: 32];
      return f;
   endfunction

   // Memory model: block contents are a fixed function of the block address.
   assign bus.mem_rdata = bus.mem_re ? pattern(bus.mem_addr) : '0;

   always @(posedge clk) begin
      if (bus.i_ack) i_ack_cnt <= i_ack_cnt + 1;
      if (bus.d_ack) d_ack_cnt <= d_ack_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_ack(input bit on_d);
      int n = 0;
      do begin
         tick();
         n++;
      end while (((on_d ? bus.d_ack : bus.i_ack) == 1'b0) && n < 40);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int   t0, t1, i_before, d_before;
      logic any;

      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_lock = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.flush_req = 1'b0;

      // Reset held with icache already requesting.
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h0000_04A3;
      repeat (3) tick();
      check("rst_ctrl", {bus.i_ack, bus.d_ack, bus.mem_re, bus.mem_we, bus.mem_flush}, 5'b0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", fold(bus.mem_wdata), 0);
      check("rst_rdata", {fold(bus.i_rdata), fold(bus.d_rdata)}, 64'h0);

      rst = 1'b0;
      t0  = cyc;
      tick();
      check("first_re", bus.mem_re, 1);
      check("first_addr", bus.mem_addr, 32'h0000_0480);
      wait_ack(1'b0);
      check("lone_ack_cyc", cyc - t0, 5);
      check("lone_rdata", fold(bus.i_rdata), fold(pattern(32'h0000_0480)));
      check("lone_no_dack", d_ack_cnt, 0);
      tick();
      check("lone_ack_pulse", bus.i_ack, 0);
      bus.i_req = 1'b0;

      // Contention with last_grant = I: dcache first, icache 6 cycles later.
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_1234;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2010;
      t0 = cyc;
      tick();
      check("rr_first_addr", bus.mem_addr, 32'h0000_2000);
      wait_ack(1'b1);
      check("rr_d_ack_cyc", cyc - t0, 5);
      check("rr_d_rdata", fold(bus.d_rdata), fold(pattern(32'h0000_2000)));
      t1 = cyc;
      tick();
      bus.d_req = 1'b0;
      wait_ack(1'b0);
      check("rr_ack_gap", cyc - t1, 6);
      check("rr_i_rdata", fold(bus.i_rdata), fold(pattern(32'h0000_1200)));
      check("rr_d_hold", fold(bus.d_rdata), fold(pattern(32'h0000_2000)));
      tick();
      bus.i_req = 1'b0;

      // Locked write-back then refill; icache must wait for the refill ack.
      i_before = i_ack_cnt;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_lock = 1'b1;
      bus.d_addr = 32'h0000_0400; bus.d_wdata = pattern(32'hDEAD_0000);
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_3000;
      t0 = cyc;
      tick();
      check("wb_strobes", {bus.mem_we, bus.mem_re}, 2'b10);
      check("wb_addr", bus.mem_addr, 32'h0000_0400);
      check("wb_wdata", fold(bus.mem_wdata), fold(pattern(32'hDEAD_0000)));
      wait_ack(1'b1);
      check("wb_ack_cyc", cyc - t0, 5);
      tick();
      bus.d_req = 1'b0; bus.d_lock = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0800;
      tick();
      check("lock_hold", {bus.mem_re, bus.mem_we}, 2'b00);
      bus.d_req = 1'b1;
      t0 = cyc;
      tick();
      check("refill_strobes", {bus.mem_we, bus.mem_re}, 2'b01);
      check("refill_addr", bus.mem_addr, 32'h0000_0800);
      wait_ack(1'b1);
      check("refill_ack_cyc", cyc - t0, 5);
      check("refill_rdata", fold(bus.d_rdata), fold(pattern(32'h0000_0800)));
      check("lock_no_iack", i_ack_cnt - i_before, 0);
      tick();
      bus.d_req = 1'b0;
      tick();
      check("i_after_lock", {bus.mem_re, bus.mem_addr}, {1'b1, 32'h0000_3000});
      wait_ack(1'b0);
      check("i_after_lock_ack", bus.i_ack, 1);
      tick();
      bus.i_req = 1'b0;

      // Lock left set with d_req low: released after 16 idle cycles.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_lock = 1'b1; bus.d_addr = 32'h0000_5000;
      wait_ack(1'b1);
      check("safety_d_ack", bus.d_ack, 1);
      tick();
      bus.d_req = 1'b0; bus.d_lock = 1'b0;
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_6000;
      any = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         any = any | bus.mem_re | bus.mem_we;
      end
      check("safety_hold", any, 0);
      tick();
      check("safety_release", {bus.mem_re, bus.mem_addr}, {1'b1, 32'h0000_6000});
      wait_ack(1'b0);
      check("safety_i_ack", bus.i_ack, 1);
      tick();
      bus.i_req = 1'b0;

      // Flush raised while a dcache write is busy.
      d_before = d_ack_cnt;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_lock = 1'b0;
      bus.d_addr = 32'h0000_7000; bus.d_wdata = pattern(32'hBEEF_0000);
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_8000;
      tick();
      tick();
      bus.flush_req = 1'b1;
      any = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         any = any | bus.mem_flush;
      end
      check("flush_wb_ack", bus.d_ack, 1);
      check("flush_wait_busy", any, 0);
      tick();
      bus.d_req = 1'b0;
      check("flush_not_yet", bus.mem_flush, 0);
      tick();
      check("flush_on", bus.mem_flush, 1);
      any = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         any = any | bus.mem_re | bus.mem_we | ~bus.mem_flush;
      end
      check("flush_no_grant", any, 0);
      bus.flush_req = 1'b0;
      tick();
      check("flush_off", bus.mem_flush, 0);
      tick();
      check("post_flush_grant", {bus.mem_re, bus.mem_addr}, {1'b1, 32'h0000_8000});
      wait_ack(1'b0);
      check("post_flush_ack", bus.i_ack, 1);
      check("flush_one_dack", d_ack_cnt - d_before, 1);
      tick();
      bus.i_req = 1'b0;

      // Reset in the middle of a busy icache read.
      i_before = i_ack_cnt;
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_9000;
      tick();
      tick();
      check("pre_rst_re", bus.mem_re, 1);
      rst = 1'b1;
      #1;
      check("rst_async_strobes", {bus.mem_re, bus.mem_we, bus.i_ack}, 3'b000);
      check("rst_async_addr", bus.mem_addr, 0);
      bus.i_req = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (8) tick();
      check("rst_no_ack", i_ack_cnt - i_before, 0);
      check("rst_idle", {bus.mem_re, bus.mem_we, bus.mem_flush}, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
